joy_serial_mp: RTL

- Parametrised successor to the fixed 2-player DB15 serial joystick reader.
- Drives a daisy-chained 74x165 shift-register adapter on the UserIO port and deserialises PLAYERS x BITS buttons.
- Adds debounce across scans, an adapter-present detect, a change strobe, and a scan enable.
- Sits between the USER_IN/USER_OUT mux and the emu joystick merge logic; runs on CLK_JOY (40-50 MHz).

---
 rtl/joy_serial_mp.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/joy_serial_mp.sv
// Serial reader for a daisy-chained 74x165 joystick adapter: scans PLAYERS x BITS
// buttons, debounces across scans, detects adapter presence and strobes on change.
module joy_serial_mp #(
    parameter int PLAYERS  = 2,
    parameter int BITS     = 12,
    parameter int CLK_DIV  = 16,
    parameter int GAP      = 64,
    parameter int DEBOUNCE = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      joy_data,
    output logic                      joy_clk,
    output logic                      joy_load,
    output logic [PLAYERS*BITS-1:0]   joystick,
    output logic                      present,
    output logic                      update
);

    localparam int TOTAL = PLAYERS * BITS;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int K_W   = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(TOTAL - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_SAMPLE,
        S_FALL,
        S_COMMIT,
        S_WAIT
    } state_t;

    state_t             state, state_n;
    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [K_W-1:0]     k, k_n;
    logic [GAP_W-1:0]   gap_cnt, gap_n;
    logic               joy_clk_n, joy_load_n;
    logic [TOTAL-1:0]   raw, raw_n;
    logic [TOTAL-1:0]   prev;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               commit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= DB_LAST) ? DB_LAST : c + 1'b1;
    endfunction

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            k        <= '0;
            gap_cnt  <= '0;
            joy_clk  <= 1'b0;
            joy_load <= 1'b1;
            raw      <= '0;
        end else begin
            state    <= state_n;
            k        <= k_n;
            gap_cnt  <= gap_n;
            joy_clk  <= joy_clk_n;
            joy_load <= joy_load_n;
            raw      <= raw_n;
        end
    end

    // The last WAIT tick launches the next LOAD directly when enabled, so a
    // free-running scan takes 3 + 2*TOTAL + GAP ticks; IDLE is only dwelt in when en is low.
    always_comb begin
        state_n    = state;
        k_n        = k;
        gap_n      = gap_cnt;
        joy_clk_n  = joy_clk;
        joy_load_n = joy_load;
        raw_n      = raw;
        commit     = 1'b0;
        if (tick) begin
            unique case (state)
                S_IDLE: begin
                    joy_clk_n  = 1'b0;
                    joy_load_n = 1'b1;
                    if (en) begin
                        state_n    = S_LOAD;
                        joy_load_n = 1'b0;
                    end
                end
                S_LOAD: begin
                    joy_load_n = 1'b1;
                    state_n    = S_RELEASE;
                end
                S_RELEASE: begin
                    k_n     = '0;
                    state_n = S_SAMPLE;
                end
                S_SAMPLE: begin
                    raw_n[k]  = ~joy_data;
                    joy_clk_n = 1'b1;
                    state_n   = S_FALL;
                end
                S_FALL: begin
                    joy_clk_n = 1'b0;
                    if (k == K_LAST) begin
                        state_n = S_COMMIT;
                    end else begin
                        k_n     = k + 1'b1;
                        state_n = S_SAMPLE;
                    end
                end
                S_COMMIT: begin
                    commit  = 1'b1;
                    gap_n   = '0;
                    state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (en) begin
                            state_n    = S_LOAD;
                            joy_load_n = 1'b0;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        gap_n = gap_cnt + 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign cnt_n = (raw == prev) ? sat_inc(cnt) : '0;

    // All-ones raw means the data line is stuck low: no adapter on the port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            joystick <= '0;
            present  <= 1'b0;
            update   <= 1'b0;
            cnt      <= '0;
            prev     <= '0;
        end else begin
            update <= 1'b0;
            if (commit) begin
                prev <= raw;
                if (&raw) begin
                    present  <= 1'b0;
                    joystick <= '0;
                    cnt      <= '0;
                    update   <= |joystick;
                end else begin
                    present <= 1'b1;
                    cnt     <= cnt_n;
                    if (cnt_n == DB_LAST && raw != joystick) begin
                        joystick <= raw;
                        update   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
